// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if
//   Groups the issue, writeback, operand-query and commit signals of the
//   reorder buffer. Clock, reset and the global enable stay as plain ports
//   on the module.
//   slave  : the reorder buffer (consumes issue/CDB/query, drives commit)
//   master : the surrounding core (drives issue/CDB/query, observes commit)
//   Signals:
//     issueFlag/issueReg/issueBranch/issuePredTaken/issuePC : allocate request
//     issueROB, fullOut                                      : allocation status
//     cdbFlag/cdbROB/cdbData/cdbTaken/cdbTarget              : execution writeback
//     qry1ROB/qry2ROB -> qry1Ready/qry1Data, qry2Ready/qry2Data : operand lookup
//     writeFlag/writeSrc/writeReg/writeData                  : in-order commit
//     clrOut/pcOut                                           : mispredict flush
interface reorder_buffer_if #(
  parameter int unsigned ROB_WIDTH = 4,
  parameter int unsigned REG_WIDTH = 5
);
  logic                 issueFlag;
  logic [REG_WIDTH-1:0] issueReg;
  logic                 issueBranch;
  logic                 issuePredTaken;
  logic [31:0]          issuePC;
  logic [ROB_WIDTH-1:0] issueROB;
  logic                 fullOut;

  logic                 cdbFlag;
  logic [ROB_WIDTH-1:0] cdbROB;
  logic [31:0]          cdbData;
  logic                 cdbTaken;
  logic [31:0]          cdbTarget;

  logic [ROB_WIDTH-1:0] qry1ROB;
  logic [ROB_WIDTH-1:0] qry2ROB;
  logic                 qry1Ready;
  logic                 qry2Ready;
  logic [31:0]          qry1Data;
  logic [31:0]          qry2Data;

  logic                 writeFlag;
  logic [ROB_WIDTH-1:0] writeSrc;
  logic [REG_WIDTH-1:0] writeReg;
  logic [31:0]          writeData;
  logic                 clrOut;
  logic [31:0]          pcOut;

  modport slave (
    input  issueFlag, issueReg, issueBranch, issuePredTaken, issuePC,
    output issueROB, fullOut,
    input  cdbFlag, cdbROB, cdbData, cdbTaken, cdbTarget,
    input  qry1ROB, qry2ROB,
    output qry1Ready, qry2Ready, qry1Data, qry2Data,
    output writeFlag, writeSrc, writeReg, writeData, clrOut, pcOut
  );

  modport master (
    output issueFlag, issueReg, issueBranch, issuePredTaken, issuePC,
    input  issueROB, fullOut,
    output cdbFlag, cdbROB, cdbData, cdbTaken, cdbTarget,
    output qry1ROB, qry2ROB,
    input  qry1Ready, qry2Ready, qry1Data, qry2Data,
    input  writeFlag, writeSrc, writeReg, writeData, clrOut, pcOut
  );
endinterface

// File: rtl/reorder_buffer.sv
// reorder_buffer
//   Circular reorder buffer of 2^ROB_WIDTH entries. Instructions are
//   allocated at the tail, completed out of order by the CDB, and retired
//   in order from the head at most one per cycle. A mispredicted branch
//   reaching the head raises clrOut/pcOut and empties the buffer.
//   Ports:
//     clkIn : clock, rising edge
//     rstIn : asynchronous active-low reset
//     rdyIn : global enable; 0 freezes all state and suppresses commit
//     rob   : reorder_buffer_if.slave (issue, CDB, query, commit, flush)
//   Build option:
//     ROB_CDB_BYPASS_EN : when defined, operand queries also see a CDB
//                         writeback to a busy entry in the same cycle.
module reorder_buffer #(
  parameter int unsigned ROB_WIDTH = 4,
  parameter int unsigned REG_WIDTH = 5
) (
  input  logic             clkIn,
  input  logic             rstIn,
  input  logic             rdyIn,
  reorder_buffer_if.slave  rob
);
  localparam int unsigned          DEPTH      = 1 << ROB_WIDTH;
  localparam logic [ROB_WIDTH:0]   FULL_COUNT = (ROB_WIDTH+1)'(DEPTH);

  // Control bits (reset) and per-entry payload (not reset).
  logic [DEPTH-1:0]     r_busy;
  logic [DEPTH-1:0]     r_ready;
  logic [DEPTH-1:0]     r_branch;
  logic [DEPTH-1:0]     r_pred;
  logic [DEPTH-1:0]     r_act;
  logic [REG_WIDTH-1:0] r_reg    [DEPTH];
  logic [31:0]          r_data   [DEPTH];
  logic [31:0]          r_target [DEPTH];

  logic [ROB_WIDTH-1:0] r_head;
  logic [ROB_WIDTH-1:0] r_tail;
  logic [ROB_WIDTH:0]   r_count;

  logic w_full;
  logic w_commit;
  logic w_clr;
  logic w_alloc;
  logic w_wb;
  logic w_unused_pc;

  // The PC travels with the issue bundle but the buffer only needs the
  // resolved branch target, which arrives on the CDB.
  assign w_unused_pc = ^rob.issuePC;

  // fullOut comes from the registered count, so a commit in the same
  // cycle never opens a slot for an allocation.
  assign w_full   = (r_count == FULL_COUNT);
  assign w_commit = rdyIn && (r_count != '0) && r_ready[r_head];
  assign w_clr    = w_commit && r_branch[r_head] && (r_act[r_head] != r_pred[r_head]);
  assign w_alloc  = rob.issueFlag && !w_full && rdyIn && !w_clr;
  assign w_wb     = rob.cdbFlag && rdyIn && r_busy[rob.cdbROB] && !w_clr;

  // Pointer/occupancy state. Flush takes precedence over everything else
  // in the same cycle, discarding any allocate or writeback.
  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_busy  <= '0;
      r_ready <= '0;
    end else if (w_clr) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_busy  <= '0;
      r_ready <= '0;
    end else begin
      // An allocate never targets a busy entry and a writeback only
      // targets a busy one, so these index updates cannot collide.
      if (w_wb) begin
        r_ready[rob.cdbROB] <= 1'b1;
      end
      if (w_commit) begin
        r_busy[r_head] <= 1'b0;
        r_head         <= r_head + ROB_WIDTH'(1);
      end
      if (w_alloc) begin
        r_busy[r_tail]  <= 1'b1;
        r_ready[r_tail] <= 1'b0;
        r_tail          <= r_tail + ROB_WIDTH'(1);
      end
      r_count <= r_count + (ROB_WIDTH+1)'(w_alloc) - (ROB_WIDTH+1)'(w_commit);
    end
  end

  // Payload fields are only consumed when the matching busy/ready bits
  // say so, hence no reset.
  always_ff @(posedge clkIn) begin
    if (w_alloc) begin
      r_branch[r_tail] <= rob.issueBranch;
      r_pred[r_tail]   <= rob.issuePredTaken;
      r_reg[r_tail]    <= rob.issueReg;
    end
    if (w_wb) begin
      r_data[rob.cdbROB]   <= rob.cdbData;
      r_act[rob.cdbROB]    <= rob.cdbTaken;
      r_target[rob.cdbROB] <= rob.cdbTarget;
    end
  end

  always_comb begin
    rob.issueROB  = r_tail;
    rob.fullOut   = w_full;
    rob.writeSrc  = r_head;
    rob.writeReg  = r_reg[r_head];
    rob.writeData = r_data[r_head];
    rob.writeFlag = w_commit && !r_branch[r_head] && (r_reg[r_head] != '0);
    rob.clrOut    = w_clr;
    rob.pcOut     = '0;
    if (w_clr) begin
      rob.pcOut = r_target[r_head];
    end
  end

`ifdef ROB_CDB_BYPASS_EN
  logic w_byp1;
  logic w_byp2;

  assign w_byp1 = rob.cdbFlag && (rob.cdbROB == rob.qry1ROB) && r_busy[rob.cdbROB];
  assign w_byp2 = rob.cdbFlag && (rob.cdbROB == rob.qry2ROB) && r_busy[rob.cdbROB];

  always_comb begin
    rob.qry1Ready = r_ready[rob.qry1ROB] | w_byp1;
    rob.qry2Ready = r_ready[rob.qry2ROB] | w_byp2;
    rob.qry1Data  = w_byp1 ? rob.cdbData : r_data[rob.qry1ROB];
    rob.qry2Data  = w_byp2 ? rob.cdbData : r_data[rob.qry2ROB];
  end
`else
  always_comb begin
    rob.qry1Ready = r_ready[rob.qry1ROB];
    rob.qry2Ready = r_ready[rob.qry2ROB];
    rob.qry1Data  = r_data[rob.qry1ROB];
    rob.qry2Data  = r_data[rob.qry2ROB];
  end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer
//   Directed stimulus for reorder_buffer. Expected commits/flushes are
//   queued when the instruction is issued; a monitor pops and compares
//   them whenever the DUT raises writeFlag or clrOut. Timing-specific and
//   status outputs are compared directly in the stimulus thread.
module tb_reorder_buffer;
  localparam int unsigned RW = 4;
  localparam int unsigned GW = 5;

  logic clkIn = 1'b0;
  logic rstIn = 1'b0;
  logic rdyIn = 1'b1;

  reorder_buffer_if #(.ROB_WIDTH(RW), .REG_WIDTH(GW)) rob ();

  reorder_buffer #(.ROB_WIDTH(RW), .REG_WIDTH(GW)) dut (
    .clkIn (clkIn),
    .rstIn (rstIn),
    .rdyIn (rdyIn),
    .rob   (rob)
  );

  always #5 clkIn = ~clkIn;

  typedef struct {
    bit              clr;
    logic [RW-1:0]   src;
    logic [GW-1:0]   rg;
    logic [31:0]     val;
  } exp_t;

  exp_t          sb[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [RW-1:0] exp_tail = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clkIn);
    #1;
  endtask

  task automatic idle_inputs();
    rob.issueFlag      = 1'b0;
    rob.issueReg       = '0;
    rob.issueBranch    = 1'b0;
    rob.issuePredTaken = 1'b0;
    rob.issuePC        = '0;
    rob.cdbFlag        = 1'b0;
    rob.cdbROB         = '0;
    rob.cdbData        = '0;
    rob.cdbTaken       = 1'b0;
    rob.cdbTarget      = '0;
    rob.qry1ROB        = '0;
    rob.qry2ROB        = '0;
  endtask

  // Allocates one entry; push=1 queues the visible commit it will produce
  // (register write for rg!=0, flush with val as redirect PC for a branch).
  task automatic issue(input logic [GW-1:0] rg, input logic br, input logic pt,
                       input logic [31:0] val, input bit push);
    exp_t e;
    rob.issueFlag      = 1'b1;
    rob.issueReg       = rg;
    rob.issueBranch    = br;
    rob.issuePredTaken = pt;
    rob.issuePC        = 32'h0000_0400 + {27'd0, exp_tail, 1'b0};
    if (push && (br || rg != '0)) begin
      e.clr = br;
      e.src = exp_tail;
      e.rg  = rg;
      e.val = val;
      sb.push_back(e);
    end
    exp_tail = exp_tail + 1'b1;
    cyc();
    rob.issueFlag = 1'b0;
  endtask

  task automatic cdb(input logic [RW-1:0] idx, input logic [31:0] d,
                     input logic tk, input logic [31:0] tg);
    rob.cdbFlag   = 1'b1;
    rob.cdbROB    = idx;
    rob.cdbData   = d;
    rob.cdbTaken  = tk;
    rob.cdbTarget = tg;
    cyc();
    rob.cdbFlag = 1'b0;
  endtask

  task automatic do_reset();
    rstIn = 1'b0;
    idle_inputs();
    sb.delete();
    exp_tail = '0;
    cyc();
    cyc();
    check("rst_issueROB",  rob.issueROB,  0);
    check("rst_fullOut",   rob.fullOut,   0);
    check("rst_writeFlag", rob.writeFlag, 0);
    check("rst_clrOut",    rob.clrOut,    0);
    check("rst_pcOut",     rob.pcOut,     0);
    check("rst_qry1Ready", rob.qry1Ready, 0);
    rstIn = 1'b1;
  endtask

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clkIn);
      if (rstIn && (rob.writeFlag || rob.clrOut)) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected: got writeFlag=%0b clrOut=%0b src=%0d reg=%0d, expected no commit",
                   rob.writeFlag, rob.clrOut, rob.writeSrc, rob.writeReg);
        end else begin
          e = sb.pop_front();
          check("sb_clrOut",    rob.clrOut,    e.clr);
          check("sb_writeFlag", rob.writeFlag, !e.clr);
          check("sb_src",       rob.writeSrc,  e.src);
          if (e.clr) begin
            check("sb_pcOut", rob.pcOut, e.val);
          end else begin
            check("sb_writeReg",  rob.writeReg,  e.rg);
            check("sb_writeData", rob.writeData, e.val);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin
    idle_inputs();

    // In-order commit after out-of-order completion
    do_reset();
    check("t1_issueROB_0", rob.issueROB, 0);
    issue(5'd1, 1'b0, 1'b0, 32'h0000_00A1, 1'b1);
    check("t1_issueROB_1", rob.issueROB, 1);
    issue(5'd2, 1'b0, 1'b0, 32'h0000_00A2, 1'b1);
    issue(5'd3, 1'b0, 1'b0, 32'h0000_00A3, 1'b1);
    check("t1_issueROB_3", rob.issueROB, 3);
    cdb(4'd1, 32'h0000_00A2, 1'b0, 32'h0);
    check("t1_head_not_ready", rob.writeFlag, 0);
    cdb(4'd0, 32'h0000_00A1, 1'b0, 32'h0);
    check("t1_commit_x1", rob.writeFlag, 1);
    check("t1_reg_x1",    rob.writeReg,  1);
    cyc();
    check("t1_commit_x2", rob.writeFlag, 1);
    check("t1_reg_x2",    rob.writeReg,  2);
    cyc();
    check("t1_stall_x3", rob.writeFlag, 0);
    cdb(4'd2, 32'h0000_00A3, 1'b0, 32'h0);
    check("t1_commit_x3", rob.writeFlag, 1);
    cyc();
    // Correctly predicted taken branch retires silently
    issue(5'd0, 1'b1, 1'b1, 32'h0, 1'b0);
    cdb(4'd3, 32'h0, 1'b1, 32'h0000_2000);
    check("t1_brok_writeFlag", rob.writeFlag, 0);
    check("t1_brok_clrOut",    rob.clrOut,    0);
    check("t1_brok_pcOut",     rob.pcOut,     0);
    cyc();
    check("t1_issueROB_4", rob.issueROB, 4);
    issue(5'd9, 1'b0, 1'b0, 32'h0000_0099, 1'b1);
    cdb(4'd4, 32'h0000_0099, 1'b0, 32'h0);
    cyc();

    // Full buffer
    do_reset();
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check("t2_not_full_15", rob.fullOut, 0);
      issue(GW'(i + 1), 1'b0, 1'b0, 32'h0000_0100 + i, 1'b1);
    end
    check("t2_full",         rob.fullOut,  1);
    check("t2_issueROB_16",  rob.issueROB, 0);
    rob.issueFlag = 1'b1;
    rob.issueReg  = 5'd31;
    cyc();
    rob.issueFlag = 1'b0;
    check("t2_full_after_17",  rob.fullOut,  1);
    check("t2_issueROB_17",    rob.issueROB, 0);
    cdb(4'd0, 32'h0000_0100, 1'b0, 32'h0);
    check("t2_commit_while_full", rob.writeFlag, 1);
    check("t2_full_commit_cycle", rob.fullOut,   1);
    rob.issueFlag = 1'b1;
    rob.issueReg  = 5'd30;
    cyc();
    rob.issueFlag = 1'b0;
    check("t2_full_clears",        rob.fullOut,  0);
    check("t2_no_same_cycle_alloc", rob.issueROB, 0);

    // x0 destination and mispredicted branch flush
    do_reset();
    issue(5'd1, 1'b0, 1'b0, 32'h0000_0011, 1'b1);
    issue(5'd0, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1);
    issue(5'd2, 1'b0, 1'b0, 32'h0000_0022, 1'b1);
    issue(5'd0, 1'b1, 1'b0, 32'h0000_1000, 1'b1);
    issue(5'd5, 1'b0, 1'b0, 32'h0000_0055, 1'b0);
    cdb(4'd1, 32'hDEAD_BEEF, 1'b0, 32'h0);
    cdb(4'd2, 32'h0000_0022, 1'b0, 32'h0);
    cdb(4'd3, 32'h0, 1'b1, 32'h0000_1000);
    cdb(4'd0, 32'h0000_0011, 1'b0, 32'h0);
    cdb(4'd4, 32'h0000_0055, 1'b0, 32'h0);
    check("t3_x0_writeFlag", rob.writeFlag, 0);
    check("t3_x0_src",       rob.writeSrc,  1);
    cyc();
    check("t3_x2_commit", rob.writeFlag, 1);
    cyc();
    check("t3_clrOut",          rob.clrOut,    1);
    check("t3_pcOut",           rob.pcOut,     32'h0000_1000);
    check("t3_flush_writeFlag", rob.writeFlag, 0);
    rob.issueFlag = 1'b1;
    rob.issueReg  = 5'd6;
    rob.cdbFlag   = 1'b1;
    rob.cdbROB    = 4'd4;
    rob.cdbData   = 32'h0000_0666;
    cyc();
    rob.issueFlag = 1'b0;
    rob.cdbFlag   = 1'b0;
    exp_tail = '0;
    check("t3_clr_one_cycle",   rob.clrOut,   0);
    check("t3_pcOut_zero",      rob.pcOut,    0);
    check("t3_issueROB_flush",  rob.issueROB, 0);
    rob.qry1ROB = 4'd4;
    #1;
    check("t3_flushed_not_ready", rob.qry1Ready, 0);
    issue(5'd7, 1'b0, 1'b0, 32'h0000_0077, 1'b1);
    check("t3_issueROB_after", rob.issueROB, 1);
    cdb(4'd0, 32'h0000_0077, 1'b0, 32'h0);
    check("t3_src_after_flush", rob.writeSrc, 0);
    cyc();

    // Operand query, same-cycle CDB
    do_reset();
    for (int i = 0; i < 6; i++) begin
      issue(GW'(i + 1), 1'b0, 1'b0, 32'h0, 1'b0);
    end
    rob.qry1ROB = 4'd5;
    rob.qry2ROB = 4'd5;
    rob.cdbFlag = 1'b1;
    rob.cdbROB  = 4'd5;
    rob.cdbData = 32'h1234_5678;
    #1;
`ifdef ROB_CDB_BYPASS_EN
    check("t4_q1_ready_same", rob.qry1Ready, 1);
    check("t4_q1_data_same",  rob.qry1Data,  32'h1234_5678);
    check("t4_q2_ready_same", rob.qry2Ready, 1);
`else
    check("t4_q1_ready_same", rob.qry1Ready, 0);
    check("t4_q2_ready_same", rob.qry2Ready, 0);
`endif
    cyc();
    rob.cdbFlag = 1'b0;
    check("t4_q1_ready_next", rob.qry1Ready, 1);
    check("t4_q1_data_next",  rob.qry1Data,  32'h1234_5678);
    check("t4_q2_data_next",  rob.qry2Data,  32'h1234_5678);
    rob.qry1ROB = 4'd9;
    rob.cdbFlag = 1'b1;
    rob.cdbROB  = 4'd9;
    rob.cdbData = 32'h0000_CAFE;
    #1;
    check("t4_nonbusy_same", rob.qry1Ready, 0);
    cyc();
    rob.cdbFlag = 1'b0;
    check("t4_nonbusy_ignored", rob.qry1Ready, 0);

    // Pointer wrap and reset mid-stream
    do_reset();
    for (int i = 0; i < 10; i++) issue(GW'(i + 1), 1'b0, 1'b0, 32'h0000_0600 + i, 1'b1);
    for (int i = 0; i < 10; i++) cdb(RW'(i), 32'h0000_0600 + i, 1'b0, 32'h0);
    cyc();
    cyc();
    check("t5_issueROB_10", rob.issueROB, 10);
    for (int i = 0; i < 10; i++) issue(GW'(i + 11), 1'b0, 1'b0, 32'h0000_0700 + i, 1'b1);
    check("t5_tail_wrapped", rob.issueROB, 4);
    for (int i = 0; i < 10; i++) cdb(RW'(i + 10), 32'h0000_0700 + i, 1'b0, 32'h0);
    cyc();
    cyc();
    issue(5'd21, 1'b0, 1'b0, 32'h0, 1'b0);
    issue(5'd22, 1'b0, 1'b0, 32'h0, 1'b0);
    cdb(4'd4, 32'h0000_0BAD, 1'b0, 32'h0);
    check("t5_pre_reset_commit", rob.writeFlag, 1);
    rstIn = 1'b0;
    #1;
    sb.delete();
    exp_tail = '0;
    check("t5_rst_writeFlag", rob.writeFlag, 0);
    check("t5_rst_issueROB",  rob.issueROB,  0);
    check("t5_rst_fullOut",   rob.fullOut,   0);
    cyc();
    rstIn = 1'b1;
    rob.qry1ROB = 4'd4;
    cyc();
    check("t5_release_no_commit", rob.writeFlag, 0);
    check("t5_release_qry",       rob.qry1Ready, 0);

    repeat (3) cyc();
    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
